cs_stack_reader: RTL and testbench
==================================

# cs_stack_reader

Drain engine on the pop side of `cs_stack`. On `start` it pops every `Triangle3D` held in the stack and emits each one, in LIFO order, on a valid/ready stream to the downstream raster stage. A small output buffer absorbs the stack's one-cycle pop latency and downstream backpressure. The block pulses `done` once the stack and its own buffer are both empty.

## Interface
- `BUF_DEPTH`, default 3: output buffer entries; must be ≥ 3 for full throughput.
- `CNT_W`, default 16: width of `tri_count`.

Ports:
- `clk` in 1: system clock, rising edge.
- `n_rst` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request to begin a drain; ignored while `busy`.
- `busy` out 1: high from the edge after `start` until the `done` cycle, inclusive.
- `done` out 1: one-cycle pulse when the drain is complete.
- `tri_count` out CNT_W: triangles accepted downstream in the current or last drain.
- `stk_empty` in 1: `cs_stack.empty`.
- `stk_pop` out 1: drives `cs_stack.pop`.
- `stk_tri` in Triangle3D: `cs_stack.tri_out`.
- `tri_out` out Triangle3D: head of the output buffer.
- `tri_valid` out 1: `tri_out` holds a valid triangle.
- `tri_ready` in 1: downstream accepts `tri_out` on an edge where `tri_valid && tri_ready`.

## Operation
- States are IDLE, DRAIN and DONE.
  - IDLE → DRAIN on an edge with `start`=1.
  - DRAIN → DONE on an edge where `stk_empty`=1, `pop_q`=0 and `occ`=0.
  - DONE → IDLE unconditionally after one cycle.
- `done` = (state==DONE). `busy` = (state != IDLE).
- `stk_pop` = (state==DRAIN) && !`stk_empty` && (`occ` + `pop_q` < BUF_DEPTH).
  - This is combinational from registers and `stk_empty` only.
  - It has no path from `tri_ready`.
- `pop_q` is a register holding the previous cycle's `stk_pop`. When `pop_q`=1, `stk_tri` carries the popped triangle and is written into the buffer at that edge.
- The output buffer is a FIFO of BUF_DEPTH entries, with occupancy `occ` from 0 to BUF_DEPTH.
  - Write and read may occur on the same edge.
  - `tri_valid` = (`occ` != 0).
  - `tri_out` = head entry. It holds its value while `tri_valid && !tri_ready`.
- `tri_count` clears to 0 on the IDLE→DRAIN edge. It increments on each downstream handshake and saturates at 2^CNT_W−1.
- Stack empty at `start`: DRAIN lasts one cycle, no pop is issued, and `tri_count` stays 0.
- `start` in DRAIN or DONE is ignored and is not queued.
- No pop is ever issued while `stk_empty`=1. The last pop makes `cs_stack` assert `empty` on the same edge, which blocks any over-pop.
- Pushes to the stack during DRAIN are legal; those triangles are drained too.

## Timing
- Reset values: `stk_pop`=0, `tri_valid`=0, `tri_out`='0, `busy`=0, `done`=0, `tri_count`=0. State resets to IDLE, with `occ`=0 and `pop_q`=0.
- Reset mid-drain discards the buffer contents and any in-flight pop data. Stack contents are owned by `cs_stack`.
- Latency, with `start` sampled at edge 0:
  - `stk_pop` is high in cycle 1 and sampled at edge 1.
  - The triangle is captured at edge 2.
  - `tri_valid` is high after edge 2.
- Throughput with `tri_ready` held high: one triangle per cycle in steady state.
- Backpressure with `tri_ready` held low: the buffer fills to BUF_DEPTH and `stk_pop` stays 0. No triangle is lost or duplicated.
- Ready is not required to wait for valid.
- `done` occurs at least one cycle after the last handshake.

## Structure
- `Triangle3D` and `Point3D` come from `defines_package.vh`.
- Add the state enum `ReaderState` (IDLE, DRAIN, DONE) to the package.
- Sub-module `tri_fifo`: a parameterised BUF_DEPTH×Triangle3D FIFO providing `occ`, head data and simultaneous read/write.
- The FSM, pop control and counter live in `cs_stack_reader`.

## Test plan
- Basic drain, ready always high:
  - Stimulus: push 8 triangles T0..T7 into `cs_stack`, then pulse `start`.
  - Response: `tri_out` equals T7, T6, …, T0 on consecutive cycles starting 2 cycles after `start`, then a single `done` pulse, with `tri_count`=8.
- Backpressure:
  - Stimulus: 8 triangles with `tri_ready`=0 for 10 cycles after `start`, then ready toggling 1/0.
  - Response: `stk_pop` stops after 3 pops and `tri_out` is stable while stalled. All 8 arrive in order with `tri_count`=8.
- Empty stack:
  - Stimulus: `start` with the stack empty.
  - Response: `stk_pop` is never 1, `done` pulses 2 cycles after `start`, `tri_count`=0.
- Start while busy:
  - Stimulus: a second `start` during DRAIN.
  - Response: it is ignored, only one `done` pulse occurs, and `tri_count` is not cleared.
- Reset mid-drain:
  - Stimulus: assert `n_rst`=0 after 3 handshakes.
  - Response: all outputs return to reset values immediately; a subsequent `start` drains the remaining 5 triangles.
- Full-stack push during drain:
  - Stimulus: push one extra triangle TX while DRAIN is active and the stack is non-empty.
  - Response: TX is emitted before older entries, and `tri_count` includes it.

Source files
------------

// File: rtl/cs_stack_reader_pkg.sv
// Shared types for the cs_stack drain path: triangle geometry and the reader FSM encoding.
// Geometry layout matches the Point3D/Triangle3D definitions used by cs_stack.
package cs_stack_reader_pkg;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] z;
    } Point3D;

    typedef struct packed {
        Point3D v0;
        Point3D v1;
        Point3D v2;
    } Triangle3D;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } ReaderState;

    localparam int TRI_W = $bits(Triangle3D);

endpackage

// File: rtl/cs_stack_reader_fifo.sv
// Small triangle FIFO with occupancy count, combinational head and same-edge read/write.
// The head reads as zero while empty so tri_out is clean outside of valid data.
module tri_fifo
    import cs_stack_reader_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             i_wr_en,
    input  Triangle3D        i_wr_data,
    input  logic             i_rd_en,
    output Triangle3D        o_head,
    output logic [OCC_W-1:0] o_occ
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    Triangle3D        r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [OCC_W-1:0] r_occ;
    logic             w_do_wr;
    logic             w_do_rd;
    logic             w_full;
    logic             w_empty;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    assign w_full  = (r_occ == OCC_W'(DEPTH));
    assign w_empty = (r_occ == '0);
    assign w_do_rd = i_rd_en && !w_empty;
    // A full buffer may still accept a write when the head leaves on the same edge.
    assign w_do_wr = i_wr_en && (!w_full || w_do_rd);

    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= ptr_next(r_wr_ptr);
            end
            if (w_do_rd) begin
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end
            case ({w_do_wr, w_do_rd})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign o_head = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_occ  = r_occ;

endmodule

// File: rtl/cs_stack_reader.sv
// Drains cs_stack in LIFO order onto a valid/ready triangle stream, then pulses done.
// Pops are issued only when the buffer can absorb every triangle already in flight.
module cs_stack_reader
    import cs_stack_reader_pkg::*;
#(
    parameter int BUF_DEPTH = 3,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] tri_count,
    input  logic             stk_empty,
    output logic             stk_pop,
    input  Triangle3D        stk_tri,
    output Triangle3D        tri_out,
    output logic             tri_valid,
    input  logic             tri_ready
);

    localparam int OCC_W = $clog2(BUF_DEPTH + 1);

    ReaderState       r_state;
    ReaderState       w_state_next;
    logic             r_pop_q;
    logic [CNT_W-1:0] r_count;
    logic [OCC_W-1:0] w_occ;
    logic             w_pop;
    logic             w_handshake;
    logic             w_room;
    logic             w_drained;

    tri_fifo #(
        .DEPTH (BUF_DEPTH),
        .OCC_W (OCC_W)
    ) u_fifo (
        .clk       (clk),
        .n_rst     (n_rst),
        .i_wr_en   (r_pop_q),
        .i_wr_data (stk_tri),
        .i_rd_en   (w_handshake),
        .o_head    (tri_out),
        .o_occ     (w_occ)
    );

    assign tri_valid   = (w_occ != '0);
    assign w_handshake = tri_valid && tri_ready;
    // Room is judged against buffered plus in-flight entries, never against ready.
    assign w_room      = (32'(w_occ) + 32'(r_pop_q)) < 32'(BUF_DEPTH);
    assign w_drained   = stk_empty && !r_pop_q && (w_occ == '0);

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                w_pop = !stk_empty && w_room;
                if (w_drained) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= IDLE;
            r_pop_q <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_pop_q <= w_pop;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_count <= '0;
        end else if (r_state == IDLE && start) begin
            r_count <= '0;
        end else if (w_handshake && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign stk_pop   = w_pop;
    assign busy      = (r_state != IDLE);
    assign done      = (r_state == DONE);
    assign tri_count = r_count;

endmodule

// File: tb/tb_cs_stack_reader.sv
// Directed and randomized drains of a behavioural cs_stack through cs_stack_reader,
// checking stream order, timing, backpressure, reset and counter saturation.
module tb_cs_stack_reader;
    import cs_stack_reader_pkg::*;

    localparam int BUF_DEPTH = 3;
    localparam int CNT_W     = 4;

    logic             clk = 1'b0;
    logic             n_rst = 1'b1;
    logic             start = 1'b0;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] tri_count;
    logic             stk_empty = 1'b1;
    logic             stk_pop;
    Triangle3D        stk_tri = '0;
    Triangle3D        tri_out;
    logic             tri_valid;
    logic             tri_ready = 1'b0;

    logic             push_en = 1'b0;
    Triangle3D        push_data = '0;

    int        checks = 0;
    int        errors = 0;
    int        pop_cnt;
    int        hs_cnt;
    int        done_cnt;
    logic      hold_valid;
    Triangle3D held;
    Triangle3D exp_q[$];
    Triangle3D pushed[$];
    Triangle3D stk_q[$];

    cs_stack_reader #(
        .BUF_DEPTH (BUF_DEPTH),
        .CNT_W     (CNT_W)
    ) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .tri_count (tri_count),
        .stk_empty (stk_empty),
        .stk_pop   (stk_pop),
        .stk_tri   (stk_tri),
        .tri_out   (tri_out),
        .tri_valid (tri_valid),
        .tri_ready (tri_ready)
    );

    always #5 clk = ~clk;

    // Behavioural cs_stack: registered pop data, empty updates on the pop/push edge.
    always @(posedge clk) begin
        if (stk_pop && stk_q.size() != 0) begin
            stk_tri <= stk_q[$];
            stk_q.pop_back();
        end
        if (push_en) begin
            stk_q.push_back(push_data);
        end
        stk_empty <= (stk_q.size() == 0);
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic Triangle3D rand_tri();
        logic [159:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return r[143:0];
    endfunction

    function automatic logic ready_fn(input int mode, input int c, input int low);
        case (mode)
            0:       return 1'b1;
            1:       return (c < low) ? 1'b0 : (((c - low) % 2) == 0);
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    task automatic load(input int n);
        Triangle3D t;
        pushed.delete();
        for (int i = 0; i < n; i++) begin
            t = rand_tri();
            pushed.push_back(t);
            push_en   = 1'b1;
            push_data = t;
            @(posedge clk);
            @(negedge clk);
        end
        push_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic expect_lifo(input int n);
        exp_q.delete();
        for (int i = n - 1; i >= 0; i--) begin
            exp_q.push_back(pushed[i]);
        end
    endtask

    task automatic apply_reset(input string name);
        n_rst     = 1'b0;
        start     = 1'b0;
        tri_ready = 1'b0;
        push_en   = 1'b0;
        #1;
        check({name, "_rst_stk_pop"}, stk_pop, 1'b0);
        check({name, "_rst_valid"}, tri_valid, 1'b0);
        check({name, "_rst_tri_out"}, tri_out, '0);
        check({name, "_rst_busy"}, busy, 1'b0);
        check({name, "_rst_done"}, done, 1'b0);
        check({name, "_rst_count"}, tri_count, '0);
        @(negedge clk);
        n_rst      = 1'b1;
        hold_valid = 1'b0;
        exp_q.delete();
    endtask

    task automatic run_drain(input string name, input int mode, input int low,
                             input int restart_at, input int push_at, input Triangle3D push_t,
                             input int reset_hs, input int exp_pops, input int exp_cnt,
                             input int exp_done_cyc);
        int        cyc;
        int        done_cyc;
        bit        finished;
        Triangle3D want;
        pop_cnt    = 0;
        hs_cnt     = 0;
        done_cnt   = 0;
        hold_valid = 1'b0;
        cyc        = 0;
        done_cyc   = -1;
        finished   = 1'b0;
        while (!finished && cyc < 300) begin
            if (reset_hs > 0 && hs_cnt == reset_hs) begin
                apply_reset(name);
                finished = 1'b1;
            end else begin
                start     = (cyc == 0) || (cyc == restart_at);
                tri_ready = ready_fn(mode, cyc, low);
                push_en   = (cyc == push_at);
                push_data = push_t;
                check({name, "_no_overpop"}, stk_pop && stk_empty, 1'b0);
                if (stk_pop) pop_cnt++;
                if (cyc == 1) begin
                    check({name, "_busy_after_start"}, busy, 1'b1);
                    check({name, "_count_cleared"}, tri_count, '0);
                end
                if (cyc == 2) check({name, "_no_early_valid"}, tri_valid, 1'b0);
                if (cyc == 3 && exp_pops > 0) check({name, "_first_valid"}, tri_valid, 1'b1);
                if (mode == 0 && cyc >= 3 && cyc < 3 + exp_pops)
                    check({name, "_stream_gap"}, tri_valid, 1'b1);
                if (mode == 1 && cyc == low) begin
                    check({name, "_pops_when_full"}, pop_cnt, 3);
                    check({name, "_pop_stalled"}, stk_pop, 1'b0);
                end
                if (hold_valid && tri_valid) check({name, "_hold"}, tri_out, held);
                hold_valid = tri_valid && !tri_ready;
                held       = tri_out;
                if (tri_valid && tri_ready) begin
                    if (exp_q.size() == 0) begin
                        check({name, "_extra_tri"}, 1'b1, 1'b0);
                    end else begin
                        want = exp_q.pop_front();
                        check({name, "_data"}, tri_out, want);
                    end
                    hs_cnt++;
                end
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                    start    = 1'b1;
                    @(posedge clk);
                    @(negedge clk);
                    start     = 1'b0;
                    tri_ready = 1'b0;
                    push_en   = 1'b0;
                    check({name, "_idle_after_done"}, busy, 1'b0);
                    check({name, "_single_done"}, done, 1'b0);
                    @(posedge clk);
                    @(negedge clk);
                    check({name, "_start_not_queued"}, busy, 1'b0);
                    finished = 1'b1;
                end else begin
                    @(posedge clk);
                    @(negedge clk);
                    cyc++;
                end
            end
        end
        start   = 1'b0;
        push_en = 1'b0;
        check({name, "_terminated"}, finished, 1'b1);
        if (reset_hs == 0) begin
            check({name, "_tri_count"}, tri_count, exp_cnt);
            check({name, "_all_delivered"}, exp_q.size(), 0);
            check({name, "_done_pulses"}, done_cnt, 1);
            check({name, "_pop_count"}, pop_cnt, exp_pops);
            if (exp_done_cyc >= 0) check({name, "_done_cycle"}, done_cyc, exp_done_cyc);
        end
        $display("drain %s: handshakes=%0d pops=%0d tri_count=%0d", name, hs_cnt, pop_cnt, tri_count);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Triangle3D tx;
        int        n;

        #3;
        apply_reset("por");
        @(negedge clk);

        // Ready held high: LIFO stream back to back, with a second start mid-drain.
        load(8);
        expect_lifo(8);
        run_drain("basic", 0, 0, 5, -1, '0, 0, 8, 8, 12);

        // Ready low for 10 cycles then toggling: buffer fills and pops stop at 3.
        load(8);
        expect_lifo(8);
        run_drain("backpressure", 1, 10, -1, -1, '0, 0, 8, 8, -1);

        load(0);
        exp_q.delete();
        run_drain("empty", 0, 0, -1, -1, '0, 0, 0, 0, 2);

        // Reset after 3 handshakes: 5 popped so far, T2..T0 remain in the stack.
        load(8);
        expect_lifo(8);
        run_drain("reset_mid", 0, 0, -1, -1, '0, 3, 0, 0, -1);
        exp_q.delete();
        for (int i = 2; i >= 0; i--) exp_q.push_back(pushed[i]);
        run_drain("after_reset", 0, 0, -1, -1, '0, 0, 3, 3, 7);

        // TX pushed while stalled after T7,T6,T5 were popped: it overtakes T4..T0.
        load(8);
        tx = rand_tri();
        exp_q.delete();
        exp_q.push_back(pushed[7]);
        exp_q.push_back(pushed[6]);
        exp_q.push_back(pushed[5]);
        exp_q.push_back(tx);
        for (int i = 4; i >= 0; i--) exp_q.push_back(pushed[i]);
        run_drain("push_during", 1, 10, -1, 6, tx, 0, 9, 9, -1);

        for (int r = 0; r < 4; r++) begin
            n = int'($urandom_range(1, 10));
            load(n);
            expect_lifo(n);
            run_drain("random", 2, 0, -1, -1, '0, 0, n, n, -1);
        end

        // 18 handshakes against a 4-bit counter: saturates at 15.
        load(18);
        expect_lifo(18);
        run_drain("saturate", 0, 0, -1, -1, '0, 0, 18, 15, 22);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
